// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchroniser, debounce FSM, press/release strobes.
// Optional auto-repeat of press strobes while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] bi,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_strobe,  // "release" is a reserved word
  output logic             any_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    state_t                 state_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   level_reg;
    logic                   press_reg;
    logic                   release_reg;
`ifdef BTN_AUTOREPEAT_EN
    logic [RW-1:0]          rcnt_reg;
    logic                   rep_phase_reg;  // 0: waiting initial delay, 1: periodic
    logic [RW-1:0]          rep_last;
    assign rep_last = rep_phase_reg ? RP_LAST : RD_LAST;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_reg <= '0;
      else          sync_reg <= {sync_reg[SYNC_STAGES-2:0], bi[gi]};
    end
    assign s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_reg   <= IDLE;
        cnt_reg     <= '0;
        level_reg   <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rcnt_reg      <= '0;
        rep_phase_reg <= 1'b0;
`endif
      end else begin
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
        unique case (state_reg)
          IDLE: begin
            if (s) begin
              state_reg <= PRESS_WAIT;
              cnt_reg   <= CNT_ONE;
            end
          end
          PRESS_WAIT: begin
            if (!s) begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_reg <= HELD;
              cnt_reg   <= '0;
              level_reg <= 1'b1;
              press_reg <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              rcnt_reg      <= '0;
              rep_phase_reg <= 1'b0;
`endif
            end else if (cnt_reg != CNT_MAX) begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          HELD: begin
            if (!s) begin
              state_reg <= RELEASE_WAIT;
              cnt_reg   <= CNT_ONE;
`ifdef BTN_AUTOREPEAT_EN
              rcnt_reg      <= '0;
              rep_phase_reg <= 1'b0;
            end else if (rcnt_reg == rep_last) begin
              press_reg     <= 1'b1;
              rcnt_reg      <= '0;
              rep_phase_reg <= 1'b1;
            end else begin
              rcnt_reg <= rcnt_reg + RW'(1);
`endif
            end
          end
          RELEASE_WAIT: begin
            if (s) begin
              // bounce back: level never dropped, and any repeat timing restarts
              state_reg <= HELD;
              cnt_reg   <= '0;
`ifdef BTN_AUTOREPEAT_EN
              rcnt_reg      <= '0;
              rep_phase_reg <= 1'b0;
`endif
            end else if (cnt_reg == CNT_LAST) begin
              state_reg   <= IDLE;
              cnt_reg     <= '0;
              level_reg   <= 1'b0;
              release_reg <= 1'b1;
            end else if (cnt_reg != CNT_MAX) begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end
        endcase
      end
    end

    assign level[gi]          = level_reg;
    assign press[gi]          = press_reg;
    assign release_strobe[gi] = release_reg;
  end

  assign any_press = |press;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing inputs,
// compared every cycle against a run-length reference model.
module tb_button_conditioner;
  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int RD   = 20;
  localparam int RP   = 5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] bi;
  logic [N-1:0] level, press, rel;
  logic         any_press;

  int total = 0;
  int bad   = 0;

  button_conditioner #(
    .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bi(bi),
    .level(level), .press(press), .release_strobe(rel), .any_press(any_press)
  );

  always #5 clk = ~clk;

  // Reference model: a change is accepted once the synchronised input has
  // disagreed with the accepted level for DEB consecutive samples.
  logic [N-1:0] hist[$];
  int           run[N];
  int           age[N];
  bit           held[N];
  logic [N-1:0] m_level, m_press, m_rel;
  logic [N-1:0] cur;
  int           tmr[N];

  task automatic model_reset();
    hist.delete();
    m_level = '0; m_press = '0; m_rel = '0;
    for (int c = 0; c < N; c++) begin
      run[c] = 0; age[c] = 0; held[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] v);
    int e;
    logic [N-1:0] sv;
    e  = hist.size();
    sv = (e >= SYNC) ? hist[e-SYNC] : '0;
    hist.push_back(v);
    m_press = '0;
    m_rel   = '0;
    for (int c = 0; c < N; c++) begin
      if (sv[c] != m_level[c]) run[c]++;
      else                     run[c] = 0;
      if (run[c] == DEB) begin
        run[c]     = 0;
        m_level[c] = ~m_level[c];
        if (m_level[c]) m_press[c] = 1'b1;
        else            m_rel[c]   = 1'b1;
      end
`ifdef BTN_AUTOREPEAT_EN
      if (!m_level[c] || !sv[c]) held[c] = 0;
      else if (!held[c]) begin
        held[c] = 1;
        age[c]  = 0;
      end else begin
        age[c]++;
        if (age[c] >= RD && ((age[c] - RD) % RP) == 0) m_press[c] = 1'b1;
      end
`endif
    end
  endtask

  task automatic check(input string tag);
    total++;
    assert (level === m_level) else begin
      bad++; $error("FAIL %s level got=%b exp=%b", tag, level, m_level);
    end
    total++;
    assert (press === m_press) else begin
      bad++; $error("FAIL %s press got=%b exp=%b", tag, press, m_press);
    end
    total++;
    assert (rel === m_rel) else begin
      bad++; $error("FAIL %s release got=%b exp=%b", tag, rel, m_rel);
    end
    total++;
    assert (any_press === (|m_press)) else begin
      bad++; $error("FAIL %s any_press got=%b exp=%b", tag, any_press, |m_press);
    end
  endtask

  task automatic step(input logic [N-1:0] v, input string tag);
    bi = v;
    @(posedge clk);
    model_edge(v);
    #1 check(tag);
  endtask

  // Asynchronous reset asserted mid-cycle, held for n edges, released on a falling edge.
  task automatic do_reset(input int n);
    #2 reset_n = 1'b0;
    model_reset();
    #1 check("rst_async");
    repeat (n) begin
      @(posedge clk);
      #1 check("rst_hold");
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    bi      = 4'hF;
    cur     = '0;
    model_reset();
    #12 check("reset_init");
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_hold");
    end
    @(negedge clk);
    reset_n = 1'b1;

    repeat (50) step(4'b0000, "t1_idle");
    repeat (15) step(4'b0001, "t2_press");
    for (int b = 0; b < 4; b++)
      repeat (3) step((b % 2 == 0) ? 4'b0011 : 4'b0001, "t3_bounce");
    repeat (15) step(4'b0011, "t3_settle");
    repeat (12) step(4'b0111, "t4_hold");
    repeat (5)  step(4'b0011, "t4_glitch");
    repeat (5)  step(4'b0111, "t4_back");
    repeat (20) step(4'b0011, "t4_release");

    do_reset(2);
    repeat (15) step(4'b1010, "t5_concurrent");
    repeat (12) step(4'b0000, "t5_drop");
    repeat (5)  step(4'b1010, "t5_partial");
    do_reset(2);
    repeat (15) step(4'b1010, "t5_fresh");

    repeat (70) step(4'b0001, "t6_repeat");
    repeat (12) step(4'b0000, "t6_off");

    for (int c = 0; c < N; c++) tmr[c] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < N; c++) begin
        if (tmr[c] == 0) begin
          cur[c] = ~cur[c];
          tmr[c] = $urandom_range(1, 16);
        end
        tmr[c]--;
      end
      step(cur, "random");
      if (i == 400) do_reset(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
